// File: rtl/constraint_pkg.sv
// Shared types and helpers for the solver-flow constraint checkers.
// Reduction mode encodings and a width-generic saturating increment.
package constraint_pkg;

    typedef enum logic [1:0] {
        MODE_ANY  = 2'd0,
        MODE_ALL  = 2'd1,
        MODE_NONE = 2'd2,
        MODE_PAR  = 2'd3
    } red_mode_e;

    localparam int SAT_MAX_W = 32;

    // Saturates at the all-ones value of a counter that is 'width' bits wide.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                     input int unsigned width);
        logic [SAT_MAX_W-1:0] lim;
        lim = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        return (cnt >= lim) ? lim : cnt + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/constraint_lane.sv
// One constraint channel: builds the inverted shifted word for the first stage
// and reduces the already-registered word for the second stage.
module constraint_lane
    import constraint_pkg::*;
#(
    parameter int W  = 18,
    parameter int SW = 5
) (
    input  logic [W-1:0]  operand_i,
    input  logic [SW-1:0] shift_i,
    input  logic [W-1:0]  stage_word_i,
    input  red_mode_e     mode_i,
    output logic [W-1:0]  word_o,
    output logic          red_o
);

    logic [W-1:0] shifted;

    // Oversized shifts are forced to zero explicitly so the result never
    // depends on how a tool treats shift amounts beyond the operand width.
    always_comb begin
        shifted = '0;
        if (shift_i < SW'(W)) begin
            shifted = operand_i >> shift_i;
        end
        word_o = ~shifted;
    end

    always_comb begin
        red_o = 1'b0;
        case (mode_i)
            MODE_ANY:  red_o = |stage_word_i;
            MODE_ALL:  red_o = &stage_word_i;
            MODE_NONE: red_o = ~|stage_word_i;
            MODE_PAR:  red_o = ^stage_word_i;
            default:   red_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/constraint_stream_checker.sv
// Two-stage valid/ready pipeline evaluating N shift-and-reduce constraints per
// beat, streaming their conjunction and keeping saturating pass/fail counts.
module constraint_stream_checker
    import constraint_pkg::*;
#(
    parameter int W  = 18,
    parameter int N  = 4,
    parameter int SW = $clog2(W + 1),
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [N*SW-1:0] in_shift,
    input  logic [N*2-1:0]  in_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_x,
    output logic [N-1:0]    out_chan,
    input  logic            clear,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt
);

    logic                  s1_valid_q, s1_valid_d;
    logic [N-1:0][W-1:0]   s1_word_q, s1_word_d;
    red_mode_e [N-1:0]     s1_mode_q, s1_mode_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [N-1:0]          chan_q, chan_d;
    logic                  x_q, x_d;
    logic [CW-1:0]         pass_q, pass_d;
    logic [CW-1:0]         fail_q, fail_d;

    logic [N-1:0][W-1:0]   lane_word;
    logic [N-1:0]          lane_red;
    logic                  accept, deliver, s1_advance;

    for (genvar k = 0; k < N; k++) begin : g_lane
        constraint_lane #(.W(W), .SW(SW)) u_lane (
            .operand_i    (in_data[k*W +: W]),
            .shift_i      (in_shift[k*SW +: SW]),
            .stage_word_i (s1_word_q[k]),
            .mode_i       (s1_mode_q[k]),
            .word_o       (lane_word[k]),
            .red_o        (lane_red[k])
        );
    end

    assign deliver    = s2_valid_q && out_ready;
    assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        chan_d     = chan_q;
        x_d        = x_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_word_d  = lane_word;
            for (int k = 0; k < N; k++) begin
                s1_mode_d[k] = red_mode_e'(in_mode[k*2 +: 2]);
            end
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
        // The output registers only change on a load, so they hold while stalled.
        if (s1_advance) begin
            s2_valid_d = 1'b1;
            chan_d     = lane_red;
            x_d        = &lane_red;
        end else if (deliver) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (clear) begin
            pass_d = '0;
            fail_d = '0;
        end else if (deliver) begin
            if (x_q) begin
                pass_d = CW'(sat_inc(SAT_MAX_W'(pass_q), CW));
            end else begin
                fail_d = CW'(sat_inc(SAT_MAX_W'(fail_q), CW));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_mode_q  <= {N{MODE_ANY}};
            s2_valid_q <= 1'b0;
            chan_q     <= '0;
            x_q        <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            chan_q     <= chan_d;
            x_q        <= x_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_x     = x_q;
    assign out_chan  = chan_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_constraint_stream_checker.sv
// Directed bench for constraint_stream_checker: latency, modes, backpressure,
// saturation with a 4-bit counter, clear priority and mid-stream reset.
module tb_constraint_stream_checker;

    localparam int W  = 18;
    localparam int N  = 4;
    localparam int SW = 5;
    localparam int CW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  in_data;
    logic [N*SW-1:0] in_shift;
    logic [N*2-1:0]  in_mode;
    logic            out_valid;
    logic            out_ready;
    logic            out_x;
    logic [N-1:0]    out_chan;
    logic            clear;
    logic [CW-1:0]   pass_cnt;
    logic [CW-1:0]   fail_cnt;

    int checkCount = 0;
    int passCount  = 0;

    constraint_stream_checker #(.W(W), .N(N), .SW(SW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_chan  (out_chan),
        .clear     (clear),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Every channel shifted fully out in ALL mode, so it contributes a 1.
    task automatic setDefaults();
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W]   = 18'h15555;
            in_shift[k*SW +: SW] = 5'd18;
            in_mode[k*2 +: 2]   = 2'd1;
        end
    endtask

    task automatic applyStimulus(input int k, input logic [W-1:0] d,
                                 input logic [SW-1:0] s, input logic [1:0] m);
        setDefaults();
        in_data[k*W +: W]    = d;
        in_shift[k*SW +: SW] = s;
        in_mode[k*2 +: 2]    = m;
    endtask

    task automatic runBeat(input string tag, input logic [3:0] expChan, input logic expX);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_chan"}, 32'(out_chan), 32'(expChan));
        checkOutput({tag, "_x"}, 32'(out_x), 32'(expX));
        @(negedge clk);
        checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int sent;
        int deliv;
        int cyc;
        logic expX [6];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        setDefaults();
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_x", 32'(out_x), 32'd0);
        checkOutput("rst_out_chan", 32'(out_chan), 32'd0);
        checkOutput("rst_pass", 32'(pass_cnt), 32'd0);
        checkOutput("rst_fail", 32'(fail_cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // r0 = ~(3FFFF >> 9) = 3FE00, ANY -> 1
        applyStimulus(0, 18'h3FFFF, 5'd9, 2'd0);
        runBeat("t1", 4'hF, 1'b1);
        checkOutput("t1_pass", 32'(pass_cnt), 32'd1);
        checkOutput("t1_fail", 32'(fail_cnt), 32'd0);

        applyStimulus(2, 18'h3FFFF, 5'd0, 2'd0);
        runBeat("t2", 4'hB, 1'b0);
        checkOutput("t2_fail", 32'(fail_cnt), 32'd1);

        // Mode sweep, r0 = 1
        applyStimulus(0, 18'h3FFFE, 5'd0, 2'd0); runBeat("any1", 4'hF, 1'b1);
        applyStimulus(0, 18'h3FFFE, 5'd0, 2'd1); runBeat("all1", 4'hE, 1'b0);
        applyStimulus(0, 18'h3FFFE, 5'd0, 2'd2); runBeat("none1", 4'hE, 1'b0);
        applyStimulus(0, 18'h3FFFE, 5'd0, 2'd3); runBeat("par1", 4'hF, 1'b1);
        applyStimulus(0, 18'h00000, 5'd0, 2'd1); runBeat("all0", 4'hF, 1'b1);
        applyStimulus(0, 18'h00000, 5'd0, 2'd3); runBeat("par0", 4'hE, 1'b0);
        checkOutput("sweep_pass", 32'(pass_cnt), 32'd4);
        checkOutput("sweep_fail", 32'(fail_cnt), 32'd4);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_pass", 32'(pass_cnt), 32'd0);
        checkOutput("clr_fail", 32'(fail_cnt), 32'd0);

        // Backpressure: out_ready low in cycles 3..6; even beats pass, odd fail.
        for (int i = 0; i < 6; i++) expX[i] = (i % 2 == 0);
        sent = 0; deliv = 0; cyc = 0;
        while (deliv < 6 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent % 2 == 0) applyStimulus(0, 18'h3FFFF, 5'd9, 2'd0);
            else               applyStimulus(0, 18'h3FFFF, 5'd0, 2'd0);
            in_valid = (sent < 6);
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                checkOutput("bp_held_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_held_x", 32'(out_x), 32'(expX[deliv]));
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp_x%0d", deliv), 32'(out_x), 32'(expX[deliv]));
                checkOutput($sformatf("bp_chan%0d", deliv), 32'(out_chan),
                            expX[deliv] ? 32'hF : 32'hE);
                deliv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("bp_delivered", 32'(deliv), 32'd6);
        checkOutput("bp_total", 32'(pass_cnt) + 32'(fail_cnt), 32'd6);
        checkOutput("bp_pass", 32'(pass_cnt), 32'd3);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Saturation: 20 passing deliveries into a 4-bit counter.
        applyStimulus(0, 18'h3FFFF, 5'd9, 2'd0);
        out_ready = 1'b1;
        sent = 0; deliv = 0; cyc = 0;
        while (deliv < 20 && cyc < 80) begin
            in_valid = (sent < 20);
            #1;
            if (out_valid && out_ready) deliv++;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("sat_delivered", 32'(deliv), 32'd20);
        checkOutput("sat_pass", 32'(pass_cnt), 32'hF);
        checkOutput("sat_fail", 32'(fail_cnt), 32'd0);

        // Clear coinciding with a delivery must win.
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clrdel_valid", 32'(out_valid), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clrdel_pass", 32'(pass_cnt), 32'd0);
        checkOutput("clrdel_drained", 32'(out_valid), 32'd0);

        // Mid-stream reset with two beats held in the pipe.
        runBeat("pre_rst", 4'hF, 1'b1);
        checkOutput("pre_rst_pass", 32'(pass_cnt), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_valid", 32'(out_valid), 32'd1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_pass", 32'(pass_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_valid%0d", i), 32'(out_valid), 32'd0);
        end
        checkOutput("post_rst_pass", 32'(pass_cnt), 32'd0);
        checkOutput("post_rst_fail", 32'(fail_cnt), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
